// File: rtl/relu_arb_pkg.sv
// Shared definitions for the shared-ReLU arbiter: default data width,
// the rectifier and the requester-id width helper.
package relu_arb_pkg;

  localparam int DATA_W_DEF = 9;
  localparam int RELU_MAX_W = 64;

  // Tag width for a given requester count; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width-generic rectifier: operand is zero-extended into RELU_MAX_W bits,
  // w is the real data width, so bit w-1 is the sign.
  function automatic logic [RELU_MAX_W-1:0] relu(input logic [RELU_MAX_W-1:0] d,
                                                 input int w);
    logic [RELU_MAX_W-1:0] ones;
    logic [RELU_MAX_W-1:0] mask;
    logic                  neg;
    ones = '1;
    mask = ones >> (RELU_MAX_W - w);
    neg  = |(d & (RELU_MAX_W'(1) << (w - 1)));
    return neg ? '0 : (d & mask);
  endfunction

endpackage

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with a burst lock: the last winner keeps the grant for
// up to BURST consecutive transfers while it stays valid.
module rr_burst_arbiter
  import relu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int BURST   = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               accept,
  input  logic               fire,
  output logic [NUM_REQ-1:0] grant
);

  localparam int CNT_W = $clog2(BURST + 1);

  logic [ID_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  gnt_idx;
  logic             found;
  logic             lock;
  int               j;

  always_comb begin
    lock    = req_valid[owner_q] && (cnt_q < CNT_W'(BURST));
    found   = lock;
    gnt_idx = owner_q;
    j       = 0;
    // Search ends on owner itself, so a lone requester past its burst is re-granted.
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(owner_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_valid[ID_W'(j)]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(j);
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = found && accept && (gnt_idx == ID_W'(i));
    end
  end

  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (fire) begin
      if (lock) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        owner_d = gnt_idx;
        cnt_d   = CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= ID_W'(NUM_REQ - 1);
      cnt_q   <= CNT_W'(BURST);
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/relu_share_arb.sv
// One registered ReLU stage shared by NUM_REQ requesters through a
// burst-limited round-robin arbiter; results carry the requester index.
module relu_share_arb
  import relu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BURST   = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  input  logic                      out_ready
);

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic              accept;
  logic              fire;
  logic [NUM_REQ-1:0] grant;
  logic [DATA_W-1:0] mux_data;

  // Held low during reset so no requester sees a handshake that gets discarded.
  assign accept = (!out_valid_q || out_ready) && !rst;

  rr_burst_arbiter #(
    .NUM_REQ (NUM_REQ),
    .BURST   (BURST),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .accept    (accept),
    .fire      (fire),
    .grant     (grant)
  );

  assign req_ready = grant;
  assign fire      = |(req_valid & grant);

  always_comb begin
    mux_data = '0;
    out_id_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mux_data = req_data[i*DATA_W +: DATA_W];
        out_id_d = ID_W'(i);
      end
    end
    out_data_d = DATA_W'(relu(RELU_MAX_W'(mux_data), DATA_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else if (fire) begin
      out_valid_q <= 1'b1;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_relu_share_arb.sv
// Self-checking bench for relu_share_arb: directed vector table, hand-written
// corner sequences and randomized traffic against a reference model.
module tb_relu_share_arb;

  localparam int N = 4;
  localparam int B = 4;
  localparam int W = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [1:0]    out_id;
  logic          out_ready;

  relu_share_arb #(.NUM_REQ(N), .DATA_W(W), .BURST(B)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  int         m_owner = N - 1;
  int         m_cnt   = B;
  logic       m_ov    = 1'b0;
  logic [8:0] m_od    = '0;
  logic [1:0] m_oid   = '0;

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic [35:0] d;
    logic        ordy;
    logic        ev;
    logic [8:0]  ed;
    logic [1:0]  eid;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] pk(input logic [8:0] a0, input logic [8:0] a1,
                                     input logic [8:0] a2, input logic [8:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [35:0] d,
                              input logic ordy, input logic ev, input logic [8:0] ed,
                              input logic [1:0] eid);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.ordy = ordy; t.ev = ev; t.ed = ed; t.eid = eid;
    return t;
  endfunction

  // Who should win this cycle: the owner while its burst allowance lasts,
  // otherwise the first valid requester walking round from owner+1.
  function automatic int m_grant(input logic [3:0] v);
    if (v[m_owner] && m_cnt < B) return m_owner;
    for (int k = 1; k <= N; k++) begin
      if (v[(m_owner + k) % N]) return (m_owner + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [8:0] m_relu(input logic [8:0] x);
    return (int'(x) >= 256) ? 9'd0 : x;
  endfunction

  task automatic cycle(input logic r, input logic [3:0] v, input logic [35:0] d,
                       input logic ordy);
    int         g;
    logic       acc;
    logic [3:0] exp_rdy;
    rst = r; req_valid = v; req_data = d; out_ready = ordy;
    #1;
    g       = m_grant(v);
    acc     = !m_ov || ordy;
    exp_rdy = (!r && acc && g >= 0) ? 4'(1 << g) : 4'd0;
    chk("req_ready", 36'(req_ready), 36'(exp_rdy));
    @(posedge clk);
    #1;
    if (r) begin
      m_ov = 1'b0; m_od = '0; m_oid = '0; m_owner = N - 1; m_cnt = B;
    end else if (exp_rdy != 0) begin
      m_od  = m_relu(d[g*W +: W]);
      m_oid = 2'(g);
      m_ov  = 1'b1;
      if (g == m_owner && m_cnt < B) m_cnt = m_cnt + 1;
      else begin
        m_owner = g;
        m_cnt   = 1;
      end
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    chk("out_valid", 36'(out_valid), 36'(m_ov));
    chk("out_data", 36'(out_data), 36'(m_od));
    chk("out_id", 36'(out_id), 36'(m_oid));
  endtask

  logic [8:0] burst_exp [4];

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;

    burst_exp[0] = 9'h0A5; burst_exp[1] = 9'h010; burst_exp[2] = 9'h000; burst_exp[3] = 9'h030;

    tbl.push_back(mk(1, 4'hF, pk(9'h005, 9'h005, 9'h005, 9'h005), 1, 0, 9'h000, 0));
    tbl.push_back(mk(0, 4'h1, pk(9'h005, 0, 0, 0), 1, 1, 9'h005, 0));
    tbl.push_back(mk(0, 4'h0, pk(0, 0, 0, 0), 1, 0, 9'h005, 0));
    tbl.push_back(mk(0, 4'h4, pk(0, 0, 9'h100, 0), 1, 1, 9'h000, 2));
    tbl.push_back(mk(0, 4'h4, pk(0, 0, 9'h1FF, 0), 1, 1, 9'h000, 2));
    tbl.push_back(mk(0, 4'h4, pk(0, 0, 9'h0FF, 0), 1, 1, 9'h0FF, 2));
    tbl.push_back(mk(0, 4'h4, pk(0, 0, 9'h000, 0), 1, 1, 9'h000, 2));
    tbl.push_back(mk(0, 4'h0, pk(0, 0, 0, 0), 1, 0, 9'h000, 2));
    tbl.push_back(mk(1, 4'h0, pk(0, 0, 0, 0), 1, 0, 9'h000, 0));
    for (int k = 0; k < 17; k++) begin
      tbl.push_back(mk(0, 4'hF, pk(9'h0A5, 9'h010, 9'h1F0, 9'h030), 1, 1,
                       burst_exp[(k / 4) % 4], 2'((k / 4) % 4)));
    end

    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].ordy);
      chk("tbl_valid", 36'(out_valid), 36'(tbl[i].ev));
      chk("tbl_data", 36'(out_data), 36'(tbl[i].ed));
      chk("tbl_id", 36'(out_id), 36'(tbl[i].eid));
    end

    // early release: requester 1 owns with cnt=2, drops valid, 3 takes over with cnt=1
    cycle(1, 4'h0, '0, 1);
    cycle(0, 4'h2, pk(0, 9'h011, 0, 0), 1);
    cycle(0, 4'h2, pk(0, 9'h012, 0, 0), 1);
    cycle(0, 4'h8, pk(0, 0, 0, 9'h013), 1);
    chk("early_rel_id", 36'(out_id), 36'd3);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 4'hA, pk(0, 9'h014, 0, 9'h015), 1);
      chk("early_rel_lock", 36'(out_id), 36'd3);
    end
    cycle(0, 4'hA, pk(0, 9'h014, 0, 9'h015), 1);
    chk("early_rel_rot", 36'(out_id), 36'd1);

    // backpressure: five stalled cycles, then transfer in the same cycle ready returns
    cycle(0, 4'h1, pk(9'h011, 0, 0, 0), 1);
    chk("bp_first", 36'(out_data), 36'h011);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 4'h1, pk(9'h022, 0, 0, 0), 0);
      chk("bp_hold_data", 36'(out_data), 36'h011);
      chk("bp_hold_id", 36'(out_id), 36'd0);
      chk("bp_hold_valid", 36'(out_valid), 36'd1);
    end
    cycle(0, 4'h1, pk(9'h033, 0, 0, 0), 1);
    chk("bp_release", 36'(out_data), 36'h033);
    cycle(0, 4'h3, pk(9'h034, 9'h035, 0, 0), 1);
    cycle(0, 4'h3, pk(9'h034, 9'h035, 0, 0), 1);
    chk("bp_cnt_kept", 36'(out_id), 36'd0);
    cycle(0, 4'h3, pk(9'h034, 9'h035, 0, 0), 1);
    chk("bp_cnt_rot", 36'(out_id), 36'd1);

    // reset mid-burst with a pending result
    cycle(1, 4'h0, '0, 1);
    cycle(0, 4'h4, pk(0, 0, 9'h044, 0), 1);
    cycle(0, 4'h4, pk(0, 0, 9'h045, 0), 1);
    chk("rmb_pending", 36'(out_valid), 36'd1);
    cycle(1, 4'h5, pk(9'h066, 0, 9'h046, 0), 0);
    chk("rmb_flushed", 36'(out_valid), 36'd0);
    cycle(0, 4'h5, pk(9'h066, 0, 9'h077, 0), 1);
    chk("rmb_next_id", 36'(out_id), 36'd0);
    chk("rmb_next_data", 36'(out_data), 36'h066);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic [35:0] rd;
      rd = {$urandom, $urandom} & 64'hF_FFFF_FFFF;
      cycle(($urandom_range(0, 49) == 0), 4'($urandom), rd, ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
